// File: rtl/wallace_final_adder_pipe_pkg.sv
// Shared MAC constants and the Wallace-tree-to-CPA interface bundle.
package wallace_final_adder_pipe_pkg;

  localparam int MAC_MANT = 23;
  localparam int MAC_W    = 2*MAC_MANT + 3;
  localparam int MAC_LO   = MAC_MANT + 2;

  typedef struct packed {
    logic [MAC_W-1:0] sum;
    logic [MAC_W-1:0] carry;
    logic             supp;
  } wallace_pair_t;

endpackage

// File: rtl/wallace_final_adder_pipe_cpa_segment.sv
// Combinational N-bit carry-propagate adder segment with carry in/out.
module wallace_final_adder_pipe_cpa_segment #(
  parameter int N = 25
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};

endmodule

// File: rtl/wallace_final_adder_pipe.sv
// Two-stage split CPA resolving the Wallace tree sum/carry pair into a binary
// mantissa product, with valid/ready backpressure between stages.
module wallace_final_adder_pipe
  import wallace_final_adder_pipe_pkg::*;
#(
  parameter int PARM_MANT = MAC_MANT,
  parameter int PARM_LO   = PARM_MANT + 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2*PARM_MANT+2:0] wallace_sum_i,
  input  logic [2*PARM_MANT+2:0] wallace_carry_i,
  input  logic                   suppression_sign_extension_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2*PARM_MANT+2:0] product_o,
  output logic                   norm_shift_o,
  output logic                   zero_o,
  output logic                   suppression_o
);

  localparam int W  = 2*PARM_MANT + 3;
  localparam int HI = W - PARM_LO;

  // [0] = S1 valid, [1] = S2 valid
  logic [1:0]         r_vld_pipe;
  logic [PARM_LO-1:0] r_lo;
  logic               r_c1;
  logic [HI-1:0]      r_sum_hi;
  logic [HI-1:0]      r_carry_hi;
  logic               r_s1_supp;
  logic [W-1:0]       r_prod;
  logic               r_norm;
  logic               r_zero;
  logic               r_s2_supp;

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic [PARM_LO-1:0] w_lo_sum;
  logic               w_lo_cout;
  logic [HI-1:0]      w_hi_sum;
  logic               w_unused_hi_cout;
  logic [W-1:0]       w_prod;

  assign w_s2_adv   = !r_vld_pipe[1] | out_ready_i;
  assign w_s1_adv   = !r_vld_pipe[0] | w_s2_adv;
  assign in_ready_o = w_s1_adv;

  wallace_final_adder_pipe_cpa_segment #(.N(PARM_LO)) u_cpa_lo (
    .i_a    (wallace_sum_i[PARM_LO-1:0]),
    .i_b    (wallace_carry_i[PARM_LO-1:0]),
    .i_cin  (1'b0),
    .o_sum  (w_lo_sum),
    .o_cout (w_lo_cout)
  );

  // High segment carry-out falls off the top: the product is mod 2^W.
  wallace_final_adder_pipe_cpa_segment #(.N(HI)) u_cpa_hi (
    .i_a    (r_sum_hi),
    .i_b    (r_carry_hi),
    .i_cin  (r_c1),
    .o_sum  (w_hi_sum),
    .o_cout (w_unused_hi_cout)
  );

  assign w_prod = {w_hi_sum, r_lo};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_pipe <= '0;
      r_lo       <= '0;
      r_c1       <= 1'b0;
      r_sum_hi   <= '0;
      r_carry_hi <= '0;
      r_s1_supp  <= 1'b0;
      r_prod     <= '0;
      r_norm     <= 1'b0;
      r_zero     <= 1'b0;
      r_s2_supp  <= 1'b0;
    end else begin
      if (in_valid_i && w_s1_adv) begin
        r_vld_pipe[0] <= 1'b1;
        r_lo          <= w_lo_sum;
        r_c1          <= w_lo_cout;
        r_sum_hi      <= wallace_sum_i[W-1:PARM_LO];
        r_carry_hi    <= wallace_carry_i[W-1:PARM_LO];
        r_s1_supp     <= suppression_sign_extension_i;
      end else if (w_s1_adv) begin
        r_vld_pipe[0] <= 1'b0;
      end

      if (r_vld_pipe[0] && w_s2_adv) begin
        r_vld_pipe[1] <= 1'b1;
        r_prod        <= w_prod;
        r_norm        <= w_prod[2*PARM_MANT+1];
        r_zero        <= (w_prod == '0);
        r_s2_supp     <= r_s1_supp;
      end else if (out_ready_i) begin
        r_vld_pipe[1] <= 1'b0;
      end
    end
  end

  assign out_valid_o   = r_vld_pipe[1];
  assign product_o     = r_prod;
  assign norm_shift_o  = r_norm;
  assign zero_o        = r_zero;
  assign suppression_o = r_s2_supp;

endmodule

// File: tb/tb_wallace_final_adder_pipe.sv
// Directed bench for the Wallace final adder pipeline.
module tb_wallace_final_adder_pipe;
  import wallace_final_adder_pipe_pkg::*;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [MAC_W-1:0] sum_in;
  logic [MAC_W-1:0] carry_in;
  logic             supp_in;
  logic             out_valid;
  logic             out_ready;
  logic [MAC_W-1:0] product;
  logic             norm_shift;
  logic             zero;
  logic             supp_out;

  int n_checks = 0;
  int n_fail   = 0;

  wallace_final_adder_pipe dut (
    .clk_i                        (clk),
    .rst_i                        (rst),
    .in_valid_i                   (in_valid),
    .in_ready_o                   (in_ready),
    .wallace_sum_i                (sum_in),
    .wallace_carry_i              (carry_in),
    .suppression_sign_extension_i (supp_in),
    .out_valid_o                  (out_valid),
    .out_ready_i                  (out_ready),
    .product_o                    (product),
    .norm_shift_o                 (norm_shift),
    .zero_o                       (zero),
    .suppression_o                (supp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input wallace_pair_t p, input logic v);
    sum_in   = p.sum;
    carry_in = p.carry;
    supp_in  = p.supp;
    in_valid = v;
  endtask

  // Offer one pair into an empty pipe, then check 2-cycle latency and result.
  task automatic run_single(input string name, input wallace_pair_t p,
                            input logic [MAC_W-1:0] exp_prod, input logic exp_norm,
                            input logic exp_zero, input logic exp_supp);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(p, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_early_valid got=%b exp=0", name, out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_valid got=%b exp=1", name, out_valid);
    end
    n_checks++;
    if (product !== exp_prod) begin
      n_fail++; $display("FAIL %s_product got=%h exp=%h", name, product, exp_prod);
    end
    n_checks++;
    if (norm_shift !== exp_norm) begin
      n_fail++; $display("FAIL %s_norm got=%b exp=%b", name, norm_shift, exp_norm);
    end
    n_checks++;
    if (zero !== exp_zero) begin
      n_fail++; $display("FAIL %s_zero got=%b exp=%b", name, zero, exp_zero);
    end
    n_checks++;
    if (supp_out !== exp_supp) begin
      n_fail++; $display("FAIL %s_supp got=%b exp=%b", name, supp_out, exp_supp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    n_checks++;
    if (product !== '0) begin
      n_fail++; $display("FAIL reset_product got=%h exp=0", product);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    n_checks++;
    if ({norm_shift, zero, supp_out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {norm_shift, zero, supp_out});
    end
  endtask

  task automatic test_segment_carry();
    wallace_pair_t p;
    p.sum = 49'h1FFFFFF; p.carry = 49'h1; p.supp = 1'b0;
    run_single("seg_carry", p, 49'h2000000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    wallace_pair_t p;
    p.sum = 49'h1FFFFFFFFFFFF; p.carry = 49'h1; p.supp = 1'b1;
    run_single("wrap", p, 49'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_norm();
    wallace_pair_t p;
    p.sum = 49'h900000000000; p.carry = 49'h0; p.supp = 1'b0;
    run_single("norm", p, 49'h900000000000, 1'b1, 1'b0, 1'b0);
  endtask

  // Mixed split across both segments: low half and high half both carry.
  task automatic test_mixed();
    wallace_pair_t p;
    p.sum = 49'h0_1234_5FFF_FFFF; p.carry = 49'h0_0001_0000_0001; p.supp = 1'b1;
    run_single("mixed", p, 49'h0_1235_6000_0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    wallace_pair_t p;
    int next_in  = 1;
    int next_out = 1;
    int accepted = 0;
    logic acc, emit;
    p.carry = '0; p.supp = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      out_ready = (cyc >= 4);
      p.sum = MAC_W'(next_in);
      drive(p, next_in <= 4);
      @(negedge clk);
      acc  = in_valid & in_ready;
      emit = out_valid & out_ready;
      if (cyc == 3) begin
        n_checks++;
        if (accepted !== 2) begin
          n_fail++; $display("FAIL bp_accepted got=%0d exp=2", accepted);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b1 || product !== 49'h1) begin
          n_fail++; $display("FAIL bp_hold got=%b/%h exp=1/1", out_valid, product);
        end
      end
      if (cyc >= 4 && cyc <= 7) begin
        n_checks++;
        if (emit !== 1'b1) begin
          n_fail++; $display("FAIL bp_gap cyc=%0d got=%b exp=1", cyc, emit);
        end
      end
      if (emit) begin
        n_checks++;
        if (product !== MAC_W'(next_out)) begin
          n_fail++; $display("FAIL bp_order got=%h exp=%h", product, MAC_W'(next_out));
        end
        next_out++;
      end
      @(posedge clk); #1;
      if (acc) begin
        next_in++;
        accepted++;
      end
    end
    n_checks++;
    if (next_out !== 5) begin
      n_fail++; $display("FAIL bp_count got=%0d exp=4", next_out - 1);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drained got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    wallace_pair_t p;
    p.carry = '0; p.supp = 1'b1;
    out_ready = 1'b0;
    p.sum = 49'hAA; drive(p, 1'b1);
    @(posedge clk); #1;
    p.sum = 49'hBB; drive(p, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_full got=%b/%b exp=1/0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    p.sum = 49'hCC; drive(p, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_valid got=%b exp=0", out_valid);
    end
    n_checks++;
    if (product !== '0 || supp_out !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_data got=%h/%b exp=0/0", product, supp_out);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_ghost cyc=%0d got=%b exp=0", i, out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sum_in = '0; carry_in = '0; supp_in = 1'b0;
    test_reset();
    test_segment_carry();
    test_wrap();
    test_norm();
    test_mixed();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
